// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war button front end.
package tug_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } btn_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

  // Saturating 8-bit increment used by the optional press counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    return (inc && (v != 8'hFF)) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/tug_btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce FSM with counter,
// registered one-cycle press pulse (qualified by pulse_en) and held level.
module tug_btn_debounce
  import tug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  input  logic pulse_en,
  output logic pulse,
  output logic held
);

  localparam int unsigned     DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] CNT_ONE  = DB_W'(1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  btn_state_e      state_q, state_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;
  logic            held_q, held_d;
  logic            fire;

  assign sync1_d = ~key_n;
  assign sync2_d = sync1_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = HELD;
            cnt_d   = '0;
            fire    = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed returns to HELD without a new pulse.
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pulse_d = fire & pulse_en;
  assign held_d  = (state_d == HELD) || (state_d == RELEASE_WAIT);

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign pulse = pulse_q;
  assign held  = held_q;

endmodule

// File: rtl/tug_input_cond.sv
// Two-button conditioner for the tug-of-war playfield: enable-gated L/R pulses.
// Optional TUG_PRESS_COUNT_EN adds saturating 8-bit per-player press counters.
module tug_input_cond
  import tug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_l_n,
  input  logic       key_r_n,
  input  logic       enable,
  output logic       L,
  output logic       R,
  output logic       l_held,
  output logic       r_held
`ifdef TUG_PRESS_COUNT_EN
  ,
  output logic [7:0] press_cnt_l,
  output logic [7:0] press_cnt_r
`endif
);

  // enable is applied at the firing edge inside each channel, so a press
  // seen while disabled is dropped rather than queued.
  tug_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_l_n),
    .pulse_en (enable),
    .pulse    (L),
    .held     (l_held)
  );

  tug_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_r_n),
    .pulse_en (enable),
    .pulse    (R),
    .held     (r_held)
  );

`ifdef TUG_PRESS_COUNT_EN
  logic [7:0] cnt_l_q, cnt_l_d;
  logic [7:0] cnt_r_q, cnt_r_d;

  assign cnt_l_d = sat_inc8(cnt_l_q, L);
  assign cnt_r_d = sat_inc8(cnt_r_q, R);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_l_q <= '0;
      cnt_r_q <= '0;
    end else begin
      cnt_l_q <= cnt_l_d;
      cnt_r_q <= cnt_r_d;
    end
  end

  assign press_cnt_l = cnt_l_q;
  assign press_cnt_r = cnt_r_q;
`endif

endmodule

// File: tb/tb_tug_input_cond.sv
// Directed self-checking bench for tug_input_cond at DEBOUNCE_CYCLES=4.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_tug_input_cond;

  logic clk = 1'b0;
  logic reset;
  logic key_l_n;
  logic key_r_n;
  logic enable;
  logic L, R, l_held, r_held;
`ifdef TUG_PRESS_COUNT_EN
  logic [7:0] press_cnt_l, press_cnt_r;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tug_input_cond #(.DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_l_n (key_l_n),
    .key_r_n (key_r_n),
    .enable  (enable),
    .L       (L),
    .R       (R),
    .l_held  (l_held),
    .r_held  (r_held)
`ifdef TUG_PRESS_COUNT_EN
    ,
    .press_cnt_l (press_cnt_l),
    .press_cnt_r (press_cnt_r)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and step past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    enable  = 1'b1;
    ticks(3);
    reset = 1'b0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle L %0d", i), L, 0);
      check($sformatf("idle R %0d", i), R, 0);
      check($sformatf("idle l_held %0d", i), l_held, 0);
      check($sformatf("idle r_held %0d", i), r_held, 0);
    end

    // Clean left press: pulse only after edge 5, held from edge 5.
    key_l_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("clean L %0d", i), L, (i == 5));
      check($sformatf("clean l_held %0d", i), l_held, (i >= 5));
      check($sformatf("clean R %0d", i), R, 0);
    end
    key_l_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("release l_held %0d", i), l_held, (i < 5));
      check($sformatf("release L %0d", i), L, 0);
    end

    // Bounce on right: low 2, high 1, then low; single pulse 5 edges after final fall (edge 3).
    for (int i = 0; i < 20; i++) begin
      key_r_n = (i == 2);
      tick();
      check($sformatf("bounce R %0d", i), R, (i == 8));
      check($sformatf("bounce r_held %0d", i), r_held, (i >= 8));
    end

    // Mid-hold glitches of 1..3 cycles never release or re-pulse.
    for (int g = 1; g <= 3; g++) begin
      key_r_n = 1'b1;
      for (int i = 0; i < g; i++) begin
        tick();
        check($sformatf("glitch%0d R a%0d", g, i), R, 0);
        check($sformatf("glitch%0d r_held a%0d", g, i), r_held, 1);
      end
      key_r_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        check($sformatf("glitch%0d R b%0d", g, i), R, 0);
        check($sformatf("glitch%0d r_held b%0d", g, i), r_held, 1);
      end
    end
    key_r_n = 1'b1;
    ticks(10);
    check("r released", r_held, 0);

    // Simultaneous press: L and R together, once each.
    key_l_n = 1'b0;
    key_r_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("simul L %0d", i), L, (i == 5));
      check($sformatf("simul R %0d", i), R, (i == 5));
    end
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    ticks(10);

    // Enable gating: dropped pulse while disabled, held still tracks.
    do_reset();
    enable  = 1'b0;
    key_l_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("dis L %0d", i), L, 0);
      check($sformatf("dis l_held %0d", i), l_held, (i >= 5));
    end
    key_l_n = 1'b1;
    ticks(10);
    check("dis released", l_held, 0);
    enable  = 1'b1;
    key_l_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("reen L %0d", i), L, (i == 5));
    end
`ifdef TUG_PRESS_COUNT_EN
    check("press_cnt_l after enable", press_cnt_l, 1);
    check("press_cnt_r after enable", press_cnt_r, 0);
`endif
    key_l_n = 1'b1;
    ticks(10);

    // Reset in PRESS_WAIT with key held; one pulse 6 edges after reset deasserts.
    key_l_n = 1'b0;
    ticks(3);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst L %0d", i), L, 0);
      check($sformatf("rst l_held %0d", i), l_held, 0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("post-rst L %0d", i), L, (i == 6));
      check($sformatf("post-rst l_held %0d", i), l_held, (i >= 6));
    end
    key_l_n = 1'b1;
    ticks(10);

`ifdef TUG_PRESS_COUNT_EN
    // 300 presses saturate the left counter.
    do_reset();
    for (int p = 0; p < 300; p++) begin
      key_l_n = 1'b0;
      ticks(7);
      key_l_n = 1'b1;
      ticks(7);
    end
    check("press_cnt_l saturated", press_cnt_l, 255);
    check("press_cnt_r untouched", press_cnt_r, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
